// File: rtl/beat_sequencer.sv
// Beat-index generator with tempo prescaler, start/pause control and loop/one-shot modes.
// Define BEAT_SEQ_PINGPONG_EN to enable ping-pong mode (mode 10); otherwise mode 10 acts as loop.
module beat_sequencer #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             state_reset,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] len,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] ibeat,
  output logic             beat_strobe,
  output logic             wrap,
  output logic             playing,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StPlay, StPause, StDone} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ibeat_q, ibeat_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             strobe_q, strobe_d;
  logic             wrap_q, wrap_d;
  logic             playing_q, playing_d;
  logic             done_q, done_d;
`ifdef BEAT_SEQ_PINGPONG_EN
  logic             dir_q, dir_d;  // 0 = counting up
`endif

  logic [WIDTH-1:0] last_idx;
  logic             at_last;

  // len = 0 is treated as a one-beat song
  assign last_idx = (len_q == '0) ? '0 : len_q - One;
  assign at_last  = (ibeat_q == last_idx);

  always_comb begin
    state_d  = state_q;
    ibeat_d  = ibeat_q;
    presc_d  = presc_q;
    len_d    = len_q;
    mode_d   = mode_q;
    div_d    = div_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
`ifdef BEAT_SEQ_PINGPONG_EN
    dir_d    = dir_q;
`endif
    if (state_reset) begin
      state_d = StIdle;
      ibeat_d = '0;
      presc_d = '0;
`ifdef BEAT_SEQ_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end else if (start) begin
      state_d = StPlay;
      ibeat_d = '0;
      presc_d = '0;
      len_d   = len;
      mode_d  = mode;
      div_d   = div;
`ifdef BEAT_SEQ_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        StPlay: begin
          if (pause) begin
            state_d = StPause;
          end else if (presc_q != div_q) begin
            presc_d = presc_q + DIV_W'(1);
          end else begin
            presc_d = '0;
            if (mode_q == 2'b01) begin
              // Final one-shot tick parks on the last beat without a strobe
              if (at_last) begin
                state_d = StDone;
              end else begin
                ibeat_d  = ibeat_q + One;
                strobe_d = 1'b1;
              end
`ifdef BEAT_SEQ_PINGPONG_EN
            end else if (mode_q == 2'b10) begin
              strobe_d = 1'b1;
              if (!dir_q) begin
                if (at_last) begin
                  wrap_d = 1'b1;
                  if (last_idx != '0) begin
                    ibeat_d = last_idx - One;
                    dir_d   = 1'b1;
                  end else begin
                    ibeat_d = '0;
                  end
                end else begin
                  ibeat_d = ibeat_q + One;
                end
              end else if (ibeat_q == '0) begin
                ibeat_d = One;
                dir_d   = 1'b0;
                wrap_d  = 1'b1;
              end else begin
                ibeat_d = ibeat_q - One;
              end
`endif
            end else begin
              strobe_d = 1'b1;
              if (at_last) begin
                ibeat_d = '0;
                wrap_d  = 1'b1;
              end else begin
                ibeat_d = ibeat_q + One;
              end
            end
          end
        end
        StPause: begin
          if (!pause) state_d = StPlay;
        end
        default: ;
      endcase
    end
    playing_d = (state_d == StPlay);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ibeat_q   <= '0;
      presc_q   <= '0;
      len_q     <= '0;
      mode_q    <= '0;
      div_q     <= '0;
      strobe_q  <= 1'b0;
      wrap_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef BEAT_SEQ_PINGPONG_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ibeat_q   <= ibeat_d;
      presc_q   <= presc_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      strobe_q  <= strobe_d;
      wrap_q    <= wrap_d;
      playing_q <= playing_d;
      done_q    <= done_d;
`ifdef BEAT_SEQ_PINGPONG_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign ibeat       = ibeat_q;
  assign beat_strobe = strobe_q;
  assign wrap        = wrap_q;
  assign playing     = playing_q;
  assign done        = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed self-checking bench for beat_sequencer; follows BEAT_SEQ_PINGPONG_EN when defined.
module tb_beat_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        state_reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [11:0] len = '0;
  logic [1:0]  mode = '0;
  logic [15:0] div = '0;
  logic [11:0] ibeat;
  logic        beat_strobe;
  logic        wrap;
  logic        playing;
  logic        done;

  int checks = 0;
  int errors = 0;

  beat_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .state_reset (state_reset),
    .start       (start),
    .pause       (pause),
    .len         (len),
    .mode        (mode),
    .div         (div),
    .ibeat       (ibeat),
    .beat_strobe (beat_strobe),
    .wrap        (wrap),
    .playing     (playing),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] l, input logic [1:0] m, input logic [15:0] d);
    len   = l;
    mode  = m;
    div   = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int loop_seq[5]  = '{1, 2, 3, 0, 1};
  int loop_wrap[5] = '{0, 0, 0, 1, 0};
`ifdef BEAT_SEQ_PINGPONG_EN
  int pp_seq[6]    = '{1, 2, 1, 0, 1, 2};
  int pp_wrap[6]   = '{0, 0, 1, 0, 1, 0};
`else
  int pp_seq[6]    = '{1, 2, 0, 1, 2, 0};
  int pp_wrap[6]   = '{0, 0, 1, 0, 0, 1};
`endif
  int os_seq[6]    = '{0, 1, 1, 2, 2, 2};

  initial begin
    int n;
    int strobes;

    #12;
    check("rst_ibeat", 32'(ibeat), 0);
    check("rst_strobe", 32'(beat_strobe), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;
    step();

    // Loop, len=4, div=0
    do_start(12'd4, 2'b00, 16'd0);
    check("loop_playing", 32'(playing), 1);
    check("loop_ibeat0", 32'(ibeat), 0);
    check("loop_nostrobe0", 32'(beat_strobe), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("loop_ibeat[%0d]", i), 32'(ibeat), 32'(loop_seq[i]));
      check($sformatf("loop_wrap[%0d]", i), 32'(wrap), 32'(loop_wrap[i]));
      check($sformatf("loop_strobe[%0d]", i), 32'(beat_strobe), 1);
    end

    // Tempo, len=8, div=3: one beat per 4 cycles
    do_start(12'd8, 2'b00, 16'd3);
    check("tempo_ibeat0", 32'(ibeat), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("tempo_ibeat[%0d]", k), 32'(ibeat), 32'(k / 4));
      check($sformatf("tempo_strobe[%0d]", k), 32'(beat_strobe), (k % 4 == 0) ? 1 : 0);
    end

    // One-shot, len=3, div=1
    do_start(12'd3, 2'b01, 16'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("os_ibeat[%0d]", k), 32'(ibeat), 32'(os_seq[k]));
    end
    check("os_done", 32'(done), 1);
    check("os_playing", 32'(playing), 0);
    check("os_final_strobe", 32'(beat_strobe), 0);
    check("os_final_wrap", 32'(wrap), 0);
    pause = 1'b1;
    repeat (3) step();
    pause = 1'b0;
    check("os_hold_done", 32'(done), 1);
    check("os_hold_ibeat", 32'(ibeat), 2);
    do_start(12'd3, 2'b01, 16'd1);
    check("os_restart_ibeat", 32'(ibeat), 0);
    check("os_restart_playing", 32'(playing), 1);
    check("os_restart_done", 32'(done), 0);

    // Pause mid-beat: 3 of 10 counts used, 7 remain after release
    do_start(12'd16, 2'b00, 16'd9);
    repeat (3) step();
    pause = 1'b1;
    step();
    check("pause_playing", 32'(playing), 0);
    strobes = 0;
    repeat (19) begin
      step();
      strobes += int'(beat_strobe);
    end
    check("pause_strobes", 32'(strobes), 0);
    check("pause_ibeat", 32'(ibeat), 0);
    pause = 1'b0;
    step();
    check("pause_resume_playing", 32'(playing), 1);
    n = 0;
    while (!beat_strobe && n < 50) begin
      step();
      n++;
    end
    check("pause_remaining", 32'(n), 7);
    check("pause_next_ibeat", 32'(ibeat), 1);

    // Ping-pong (or loop when the feature is absent), len=3, div=0
    do_start(12'd3, 2'b10, 16'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("pp_ibeat[%0d]", i), 32'(ibeat), 32'(pp_seq[i]));
      check($sformatf("pp_wrap[%0d]", i), 32'(wrap), 32'(pp_wrap[i]));
    end

    // len=0 behaves as len=1
    do_start(12'd0, 2'b00, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("len0_ibeat[%0d]", i), 32'(ibeat), 0);
      check($sformatf("len0_wrap[%0d]", i), 32'(wrap), 1);
    end

    // Start coincident with a tick: restart wins, no strobe
    do_start(12'd4, 2'b00, 16'd0);
    step();
    check("coinc_pre_ibeat", 32'(ibeat), 1);
    do_start(12'd4, 2'b00, 16'd0);
    check("coinc_ibeat", 32'(ibeat), 0);
    check("coinc_strobe", 32'(beat_strobe), 0);

    // Synchronous state_reset mid-play
    do_start(12'd8, 2'b00, 16'd0);
    repeat (3) step();
    check("sr_pre_ibeat", 32'(ibeat), 3);
    state_reset = 1'b1;
    step();
    state_reset = 1'b0;
    check("sr_playing", 32'(playing), 0);
    check("sr_ibeat", 32'(ibeat), 0);
    step();
    check("sr_idle_ibeat", 32'(ibeat), 0);
    check("sr_idle_playing", 32'(playing), 0);

    // Asynchronous reset between edges
    do_start(12'd8, 2'b00, 16'd0);
    repeat (3) step();
    check("ar_pre_ibeat", 32'(ibeat), 3);
    #3 reset = 1'b1;
    #1;
    check("ar_ibeat", 32'(ibeat), 0);
    check("ar_playing", 32'(playing), 0);
    check("ar_strobe", 32'(beat_strobe), 0);
    #2 reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
